// File: rtl/adc_level_monitor.sv
`default_nettype none
// ============================================================================
// Module   : adc_level_monitor
// Purpose  : Magnitude-threshold level counters, a windowed overflow
//            detector and a per-window peak-magnitude hold. All logic runs
//            in the ADC sample clock domain.
// Revision : 1.0 - initial release
// ============================================================================
module adc_level_monitor #(
    parameter int  ADC_BITS = 14,
    parameter int  NLEVELS  = 4,
    parameter int  WIN_BITS = 16,
    parameter int  CNT_BITS = 32,
    localparam int SEL_BITS = $clog2(NLEVELS + 2)
) (
    input  logic                         adc_clk,
    input  logic                         reset_n,
    input  logic signed [ADC_BITS-1:0]   adc_data,
    input  logic                         adc_ovfl,
    input  logic                         cfg_wr,
    input  logic        [SEL_BITS-1:0]   cfg_sel,
    input  logic        [31:0]           cfg_data,
    input  logic                         clr_all,
    input  logic        [SEL_BITS-1:0]   rd_sel,
    output logic        [31:0]           rd_data,
    output logic                         ovfl_pulse,
    output logic                         win_done,
    output logic        [ADC_BITS-2:0]   peak
);

    localparam int MAG_BITS = ADC_BITS - 1;
    localparam int OC_BITS  = WIN_BITS + 1;

    // Configuration state
    logic [MAG_BITS-1:0] level_q [NLEVELS];
    logic [MAG_BITS-1:0] level_d [NLEVELS];
    logic [NLEVELS-1:0]  mode_q, mode_d;
    logic [OC_BITS-1:0]  thresh_q, thresh_d;

    // Measurement state
    logic [CNT_BITS-1:0] cnt_q [NLEVELS];
    logic [CNT_BITS-1:0] cnt_d [NLEVELS];
    logic [WIN_BITS-1:0] win_ctr_q, win_ctr_d;
    logic [OC_BITS-1:0]  ovfl_cnt_q, ovfl_cnt_d;
    logic [OC_BITS-1:0]  ovfl_last_q, ovfl_last_d;
    logic [MAG_BITS-1:0] peak_run_q, peak_run_d;
    logic [MAG_BITS-1:0] peak_q, peak_d;
    logic [31:0]         rd_data_q, rd_data_d;
    logic                ovfl_pulse_q, ovfl_pulse_d;
    logic                win_done_q, win_done_d;

    // Combinational helpers
    logic [MAG_BITS-1:0] w_low;
    logic [MAG_BITS-1:0] w_mag;
    logic [MAG_BITS-1:0] w_peak_max;
    logic [OC_BITS-1:0]  w_total;
    logic                w_terminal;
    logic [NLEVELS-1:0]  w_hit;
    logic                w_unused_cfg;

    // Only a subset of cfg_data bits is meaningful for any given target.
    assign w_unused_cfg = ^cfg_data;

    // Absolute value: for a negative sample with low bits L, |x| = 2^(N-1) - L,
    // which is ~L + 1 in MAG_BITS except L == 0 (most negative), which saturates.
    assign w_low      = adc_data[MAG_BITS-1:0];
    assign w_mag      = !adc_data[ADC_BITS-1] ? w_low :
                        (w_low == '0)         ? '1    : (~w_low + MAG_BITS'(1));
    assign w_peak_max = (w_mag > peak_run_q) ? w_mag : peak_run_q;
    assign w_total    = ovfl_cnt_q + OC_BITS'(adc_ovfl);
    assign w_terminal = &win_ctr_q;

    generate
        for (genvar g = 0; g < NLEVELS; g++) begin : g_level_hit
            assign w_hit[g] = mode_q[g] ? adc_ovfl : (w_mag >= level_q[g]);
        end
    endgenerate

    // Next-state computation for counters, window, peak, config and readback
    always_comb begin
        level_d      = level_q;
        mode_d       = mode_q;
        thresh_d     = thresh_q;
        cnt_d        = cnt_q;
        win_ctr_d    = win_ctr_q + WIN_BITS'(1);
        ovfl_cnt_d   = w_total;
        ovfl_last_d  = ovfl_last_q;
        peak_run_d   = w_peak_max;
        peak_d       = peak_q;
        win_done_d   = 1'b0;
        ovfl_pulse_d = 1'b0;
        rd_data_d    = '0;

        // Saturating cumulative level counters
        for (int i = 0; i < NLEVELS; i++) begin
            if (w_hit[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
            end
        end

        // Window end: the terminal sample is counted in its own window
        if (w_terminal) begin
            win_done_d   = 1'b1;
            ovfl_pulse_d = (thresh_q != '0) && (w_total >= thresh_q);
            ovfl_last_d  = w_total;
            ovfl_cnt_d   = '0;
            peak_d       = w_peak_max;
            peak_run_d   = '0;
        end

        // Config writes; a level write also clears its counter over any increment
        if (cfg_wr) begin
            for (int i = 0; i < NLEVELS; i++) begin
                if (cfg_sel == SEL_BITS'(i)) begin
                    level_d[i] = cfg_data[MAG_BITS-1:0];
                    mode_d[i]  = cfg_data[31];
                    cnt_d[i]   = '0;
                end
            end
            if (cfg_sel == SEL_BITS'(NLEVELS)) begin
                thresh_d = cfg_data[OC_BITS-1:0];
            end
        end

        // Global clear aborts the window silently and leaves config intact
        if (clr_all) begin
            for (int i = 0; i < NLEVELS; i++) begin
                cnt_d[i] = '0;
            end
            win_ctr_d    = '0;
            ovfl_cnt_d   = '0;
            ovfl_last_d  = '0;
            peak_run_d   = '0;
            peak_d       = '0;
            win_done_d   = 1'b0;
            ovfl_pulse_d = 1'b0;
        end

        // Readback mux sees pre-update values
        for (int i = 0; i < NLEVELS; i++) begin
            if (rd_sel == SEL_BITS'(i)) begin
                rd_data_d = 32'(cnt_q[i]);
            end
        end
        if (rd_sel == SEL_BITS'(NLEVELS)) begin
            rd_data_d = 32'(peak_q);
        end
        if (rd_sel == SEL_BITS'(NLEVELS + 1)) begin
            rd_data_d = 32'(ovfl_last_q);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NLEVELS; i++) begin
                level_q[i] <= '1;
                cnt_q[i]   <= '0;
            end
            mode_q       <= '0;
            thresh_q     <= '0;
            win_ctr_q    <= '0;
            ovfl_cnt_q   <= '0;
            ovfl_last_q  <= '0;
            peak_run_q   <= '0;
            peak_q       <= '0;
            rd_data_q    <= '0;
            ovfl_pulse_q <= 1'b0;
            win_done_q   <= 1'b0;
        end else begin
            level_q      <= level_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            thresh_q     <= thresh_d;
            win_ctr_q    <= win_ctr_d;
            ovfl_cnt_q   <= ovfl_cnt_d;
            ovfl_last_q  <= ovfl_last_d;
            peak_run_q   <= peak_run_d;
            peak_q       <= peak_d;
            rd_data_q    <= rd_data_d;
            ovfl_pulse_q <= ovfl_pulse_d;
            win_done_q   <= win_done_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign ovfl_pulse = ovfl_pulse_q;
    assign win_done   = win_done_q;
    assign peak       = peak_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_level_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_level_monitor
// Purpose  : Directed self-checking bench for adc_level_monitor using a
//            short window (16 samples) and narrow 4-bit level counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_level_monitor;

    localparam int ADC_BITS = 14;
    localparam int NLEVELS  = 4;
    localparam int WIN_BITS = 4;
    localparam int CNT_BITS = 4;
    localparam int SEL_BITS = 3;

    logic                        adc_clk;
    logic                        reset_n;
    logic signed [ADC_BITS-1:0]  adc_data;
    logic                        adc_ovfl;
    logic                        cfg_wr;
    logic        [SEL_BITS-1:0]  cfg_sel;
    logic        [31:0]          cfg_data;
    logic                        clr_all;
    logic        [SEL_BITS-1:0]  rd_sel;
    logic        [31:0]          rd_data;
    logic                        ovfl_pulse;
    logic                        win_done;
    logic        [ADC_BITS-2:0]  peak;

    int checks = 0;
    int errors = 0;

    adc_level_monitor #(
        .ADC_BITS (ADC_BITS),
        .NLEVELS  (NLEVELS),
        .WIN_BITS (WIN_BITS),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .adc_clk    (adc_clk),
        .reset_n    (reset_n),
        .adc_data   (adc_data),
        .adc_ovfl   (adc_ovfl),
        .cfg_wr     (cfg_wr),
        .cfg_sel    (cfg_sel),
        .cfg_data   (cfg_data),
        .clr_all    (clr_all),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .ovfl_pulse (ovfl_pulse),
        .win_done   (win_done),
        .peak       (peak)
    );

    initial begin
        adc_clk = 1'b0;
        forever #5 adc_clk = ~adc_clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic set_data(input int v);
        adc_data = v[ADC_BITS-1:0];
    endtask

    task automatic set_rd(input int sel);
        rd_sel = sel[SEL_BITS-1:0];
    endtask

    task automatic cfg_write(input int sel, input logic [31:0] data);
        cfg_wr   = 1'b1;
        cfg_sel  = sel[SEL_BITS-1:0];
        cfg_data = data;
        tick();
        cfg_wr   = 1'b0;
    endtask

    task automatic align_window();
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) tick();
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data: got %0h want 0", rd_data); end
        checks++; if (peak !== '0) begin errors++; $display("FAIL reset_peak: got %0h want 0", peak); end
        checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL reset_win_done: got %0b want 0", win_done); end
        checks++; if (ovfl_pulse !== 1'b0) begin errors++; $display("FAIL reset_ovfl_pulse: got %0b want 0", ovfl_pulse); end
        reset_n = 1'b1;
        for (int s = 0; s < 8; s++) begin
            set_rd(s);
            tick();
            checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_read sel=%0d: got %0h want 0", s, rd_data); end
        end
    endtask

    task automatic test_level_count();
        cfg_write(0, 32'h0000_0100);
        for (int j = 0; j < 10; j++) begin
            set_data(j[0] ? -256 : 256);
            tick();
        end
        set_data(255);
        repeat (5) tick();
        set_data(0);
        cfg_write(6, 32'h0000_0000);
        set_rd(0);
        tick();
        checks++; if (rd_data !== 32'd10) begin errors++; $display("FAIL level_count: got %0d want 10", rd_data); end
        set_rd(6);
        tick();
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL read_out_of_range: got %0h want 0", rd_data); end
    endtask

    task automatic run_window(input int thr, input logic exp_pulse);
        cfg_write(NLEVELS, 32'(thr));
        align_window();
        for (int s = 0; s < 16; s++) begin
            adc_ovfl = (s >= 13);
            tick();
            if (s == 14) begin
                checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL window_early_done thr=%0d: got %0b want 0", thr, win_done); end
                checks++; if (ovfl_pulse !== 1'b0) begin errors++; $display("FAIL window_early_pulse thr=%0d: got %0b want 0", thr, ovfl_pulse); end
            end
            if (s == 15) begin
                checks++; if (win_done !== 1'b1) begin errors++; $display("FAIL window_done thr=%0d: got %0b want 1", thr, win_done); end
                checks++; if (ovfl_pulse !== exp_pulse) begin errors++; $display("FAIL window_pulse thr=%0d: got %0b want %0b", thr, ovfl_pulse, exp_pulse); end
            end
        end
        adc_ovfl = 1'b0;
        set_rd(NLEVELS + 1);
        tick();
        checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL window_done_width thr=%0d: got %0b want 0", thr, win_done); end
        checks++; if (rd_data !== 32'd3) begin errors++; $display("FAIL ovfl_last thr=%0d: got %0d want 3", thr, rd_data); end
    endtask

    task automatic test_window();
        run_window(3, 1'b1);
        run_window(4, 1'b0);
    endtask

    task automatic test_peak();
        cfg_write(1, 32'h0000_1FFF);
        set_data(0);
        align_window();
        set_data(-8192);
        repeat (5) tick();
        set_rd(1);
        tick();
        checks++; if (rd_data !== 32'd5) begin errors++; $display("FAIL most_neg_count: got %0d want 5", rd_data); end
        checks++; if (peak !== 13'h0) begin errors++; $display("FAIL peak_before_end: got %0h want 0", peak); end
        repeat (9) tick();
        checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL peak_win_early: got %0b want 0", win_done); end
        tick();
        checks++; if (win_done !== 1'b1) begin errors++; $display("FAIL peak_win_done: got %0b want 1", win_done); end
        checks++; if (peak !== 13'h1FFF) begin errors++; $display("FAIL peak_saturated: got %0h want 1fff", peak); end
        set_data(0);
        set_rd(NLEVELS);
        tick();
        checks++; if (rd_data !== 32'h1FFF) begin errors++; $display("FAIL peak_readback: got %0h want 1fff", rd_data); end
        for (int j = 1; j < 16; j++) begin
            set_data((j == 3) ? -300 : ((j == 7) ? 100 : 5));
            tick();
        end
        checks++; if (win_done !== 1'b1) begin errors++; $display("FAIL peak2_win_done: got %0b want 1", win_done); end
        checks++; if (peak !== 13'd300) begin errors++; $display("FAIL peak_max_abs: got %0d want 300", peak); end
    endtask

    task automatic test_saturation();
        set_data(0);
        cfg_write(2, 32'h0000_0000);
        repeat (20) tick();
        set_rd(2);
        tick();
        checks++; if (rd_data !== 32'd15) begin errors++; $display("FAIL cnt_saturate: got %0d want 15", rd_data); end
        cfg_wr   = 1'b1;
        cfg_sel  = 3'd2;
        cfg_data = 32'h0000_0000;
        tick();
        cfg_wr   = 1'b0;
        checks++; if (rd_data !== 32'd15) begin errors++; $display("FAIL read_during_clear: got %0d want 15", rd_data); end
        tick();
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL write_clears_cnt: got %0d want 0", rd_data); end
    endtask

    task automatic test_mode();
        cfg_write(3, 32'h8000_1FFF);
        for (int j = 0; j < 8; j++) begin
            adc_ovfl = j[0];
            set_data(j[0] ? 3 : -8192);
            tick();
        end
        adc_ovfl = 1'b0;
        set_data(0);
        set_rd(3);
        tick();
        checks++; if (rd_data !== 32'd4) begin errors++; $display("FAIL mode_ovfl_count: got %0d want 4", rd_data); end
    endtask

    task automatic test_clr_cfg();
        set_data(1234);
        adc_ovfl = 1'b1;
        repeat (5) tick();
        clr_all  = 1'b1;
        cfg_wr   = 1'b1;
        cfg_sel  = 3'(NLEVELS);
        cfg_data = 32'd1;
        tick();
        clr_all  = 1'b0;
        cfg_wr   = 1'b0;
        set_data(0);
        adc_ovfl = 1'b0;
        checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL clr_no_done: got %0b want 0", win_done); end
        checks++; if (peak !== 13'h0) begin errors++; $display("FAIL clr_peak: got %0h want 0", peak); end
        for (int j = 1; j <= 16; j++) begin
            case (j)
                1:       set_rd(0);
                2:       set_rd(1);
                3:       set_rd(3);
                4:       set_rd(NLEVELS);
                5:       set_rd(NLEVELS + 1);
                default: set_rd(2);
            endcase
            adc_ovfl = (j == 8);
            tick();
            if (j <= 5) begin
                checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL clr_read step=%0d: got %0h want 0", j, rd_data); end
            end
            if (j < 16) begin
                checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL clr_win_early step=%0d: got %0b want 0", j, win_done); end
            end else begin
                checks++; if (win_done !== 1'b1) begin errors++; $display("FAIL clr_win_done: got %0b want 1", win_done); end
                checks++; if (ovfl_pulse !== 1'b1) begin errors++; $display("FAIL clr_new_thresh_pulse: got %0b want 1", ovfl_pulse); end
            end
        end
        adc_ovfl = 1'b0;
    endtask

    task automatic test_async_reset();
        set_rd(2);
        set_data(500);
        repeat (20) tick();
        checks++; if (rd_data !== 32'd15) begin errors++; $display("FAIL pre_reset_rd: got %0d want 15", rd_data); end
        checks++; if (peak !== 13'd500) begin errors++; $display("FAIL pre_reset_peak: got %0d want 500", peak); end
        #3 reset_n = 1'b0;
        #1;
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL async_rd_data: got %0h want 0", rd_data); end
        checks++; if (peak !== 13'h0) begin errors++; $display("FAIL async_peak: got %0h want 0", peak); end
        checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL async_win_done: got %0b want 0", win_done); end
        checks++; if (ovfl_pulse !== 1'b0) begin errors++; $display("FAIL async_ovfl_pulse: got %0b want 0", ovfl_pulse); end
        #2 reset_n = 1'b1;
        set_data(0);
        adc_ovfl = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            tick();
            if (j == 15) begin
                checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL post_reset_early: got %0b want 0", win_done); end
            end
            if (j == 16) begin
                checks++; if (win_done !== 1'b1) begin errors++; $display("FAIL post_reset_done: got %0b want 1", win_done); end
                checks++; if (ovfl_pulse !== 1'b0) begin errors++; $display("FAIL thresh_zero_disables: got %0b want 0", ovfl_pulse); end
            end
        end
        adc_ovfl = 1'b0;
        set_rd(NLEVELS + 1);
        tick();
        checks++; if (rd_data !== 32'd16) begin errors++; $display("FAIL full_window_ovfl: got %0d want 16", rd_data); end
    endtask

    initial begin
        adc_data = '0;
        adc_ovfl = 1'b0;
        cfg_wr   = 1'b0;
        cfg_sel  = '0;
        cfg_data = '0;
        clr_all  = 1'b0;
        rd_sel   = '0;
        reset_n  = 1'b1;
        test_reset();
        test_level_count();
        test_window();
        test_peak();
        test_saturation();
        test_mode();
        test_clr_cfg();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_level_monitor.md
Name: adc_level_monitor

Overview:
- Parametrised successor to the receiver's single-threshold ADC overflow and level detection.
- Provides NLEVELS independent magnitude-threshold counters, a windowed overflow detector with a programmable count threshold, and a per-window peak-magnitude hold.
- Sits in the adc_clk domain between the ADC input and the CPU register interface. CPU-side strobes and data are already synchronised into adc_clk by the instantiating block.

Parameters:
- ADC_BITS, 14, signed ADC sample width.
- NLEVELS, 4, number of level-threshold counters (1..8).
- WIN_BITS, 16, overflow/peak window length is 2^WIN_BITS samples.
- CNT_BITS, 32, level counter width (max 32).
- Derived: SEL_BITS = clog2(NLEVELS+2).

Ports:
- adc_clk  in  1  sample clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- adc_data  in  ADC_BITS  signed sample.
- adc_ovfl  in  1  ADC overflow flag for this sample.
- cfg_wr  in  1  one-cycle config write strobe.
- cfg_sel  in  SEL_BITS  config target: 0..NLEVELS-1 = level i; NLEVELS = overflow threshold.
- cfg_data  in  32  config value (pre-frozen TOS).
- clr_all  in  1  one-cycle clear of all counters, window and peak.
- rd_sel  in  SEL_BITS  readback select.
- rd_data  out  32  registered readback.
- ovfl_pulse  out  1  one-cycle pulse at window end when the overflow threshold is met.
- win_done  out  1  one-cycle pulse at every window end.
- peak  out  ADC_BITS-1  peak magnitude latched from the last completed window.

Behaviour:
- Reset (async, reset_n=0):
  - All level thresholds = all-ones, mode bits = 0.
  - Overflow threshold = 0.
  - Counters, window counter, ovfl_cnt, peak_run, peak, rd_data = 0.
  - ovfl_pulse = win_done = 0.
- Magnitude:
  - mag = |adc_data| in ADC_BITS-1 bits.
  - Most-negative input saturates to 2^(ADC_BITS-1)-1. No wrap to 0.
- Level register i (written by cfg_wr with cfg_sel=i):
  - level[i] = cfg_data[ADC_BITS-2:0].
  - mode[i] = cfg_data[31].
  - The same write clears cnt[i] in that cycle; the clear has priority over an increment.
- Level counting, per sample, per i:
  - mode=0: cnt[i] increments when mag >= level[i].
  - mode=1: cnt[i] increments when adc_ovfl=1.
  - Counters saturate at 2^CNT_BITS-1; they never wrap.
  - Counters are cumulative across windows.
- Window:
  - Free-running counter win_ctr over 0..2^WIN_BITS-1.
  - The cycle with win_ctr = all-ones is the terminal sample.
- Overflow detection:
  - ovfl_cnt (WIN_BITS+1 bits) accumulates adc_ovfl per sample.
  - On the terminal sample, evaluate total = ovfl_cnt + adc_ovfl; the terminal sample is counted in its own window.
  - Next cycle: win_done=1, and ovfl_pulse=1 iff thresh != 0 and total >= thresh.
  - Then ovfl_last <= total, ovfl_cnt <= 0, win_ctr <= 0.
  - thresh = 0 disables ovfl_pulse.
  - Overflow threshold register (cfg_sel=NLEVELS): thresh = cfg_data[WIN_BITS:0]. Writing it does not restart the window.
- Peak:
  - peak_run <= max(peak_run, mag) every sample.
  - On the terminal sample: peak <= max(peak_run, mag), and peak_run <= 0.
  - peak updates in the same cycle that win_done rises.
- Readback:
  - rd_data is registered with 1-cycle latency from rd_sel.
  - 0..NLEVELS-1: cnt[i], zero-extended.
  - NLEVELS: peak, zero-extended.
  - NLEVELS+1: ovfl_last, zero-extended.
  - Any other value: 0.
  - A read in the same cycle as an increment returns the pre-increment value.
- clr_all:
  - Next cycle: all cnt, win_ctr, ovfl_cnt, ovfl_last, peak_run, peak = 0.
  - Config registers are untouched.
  - No win_done or ovfl_pulse is generated for the aborted window.
  - With simultaneous cfg_wr, the config write still occurs and the counters still clear.
- cfg_wr with an out-of-range cfg_sel is ignored.
- Reset mid-window: everything returns to reset values immediately. The first full window after release is 2^WIN_BITS samples.

Test Plan:
- Reset, then write level[0]=0x0100 with mode 0, drive mag 0x0100 for 10 cycles and 0x00FF for 5, rd_sel=0 -> rd_data=10 one cycle later.
- WIN_BITS=4, thresh=3, assert adc_ovfl on samples 13,14,15 of the window -> win_done and ovfl_pulse both pulse once at cycle 16; rd_sel=NLEVELS+1 reads 3. Repeat with thresh=4 -> win_done only.
- Drive adc_data = -2^13 with ADC_BITS=14, and level[1]=0x1FFF -> peak=0x1FFF after window end; cnt[1] increments every sample.
- CNT_BITS=4, level[2]=0, run 20 samples -> cnt[2] holds 15 with no wrap; rewrite level[2] while incrementing -> reads 0 next cycle.
- mode[3]=1, adc_ovfl toggling 50% for 8 samples -> cnt[3]=4 regardless of magnitude.
- clr_all asserted mid-window together with cfg_wr to thresh -> counters and peak 0, thresh updated, no win_done until 2^WIN_BITS samples later. Assert reset_n=0 asynchronously mid-window -> all outputs 0 without waiting for a clock edge.
